// File: rtl/rr_tdm_demux.sv
// rr_tdm_demux: de-interleaves a round-robin TDM word stream into one registered word per channel.
// Latency: din captured at edge t shows on dout with dout_valid at t+1; sync_in to dout_valid[0] is PIPE_DELAY+1 cycles.
// Backpressure: none; one word is accepted per cycle while locked, and din is dropped while unlocked.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   sync_in      one-cycle pulse marking the upstream cycle that selects channel 0
//   din          TDM data word, one per cycle
//   dout         channel k held at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid   bit k pulses when channel k updates
//   frame_valid  pulses with the capture into the last channel of an unbroken frame
//   locked       slot counter aligned
//   sync_err     pulses when a delayed sync lands on a non-zero slot
module rr_tdm_demux #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int PIPE_DELAY   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sync_in,
  input  logic [DATA_WIDTH-1:0]              din,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dout,
  output logic [NUM_CHANNELS-1:0]            dout_valid,
  output logic                               frame_valid,
  output logic                               locked,
  output logic                               sync_err
);

  localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHANNELS - 1);
  localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic [SLOT_W-1:0]       slot, slot_nxt, cap_ch;
  logic                    cap, err;
  logic [NUM_CHANNELS-1:0] dv_nxt;
  logic [PIPE_DELAY-1:0]   sync_sr;
  logic                    sync_d;
  logic [DATA_WIDTH-1:0]   chan [NUM_CHANNELS];

  // Delay line output lines the sync up with the channel-0 word on din.
  assign sync_d = sync_sr[PIPE_DELAY-1];
  assign locked = (state == LOCKED);

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_dout
    assign dout[k*DATA_WIDTH +: DATA_WIDTH] = chan[k];
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cap       = 1'b0;
    cap_ch    = slot;
    err       = 1'b0;
    dv_nxt    = '0;
    case (state)
      UNLOCKED: begin
        if (sync_d) begin
          cap       = 1'b1;
          cap_ch    = '0;
          slot_nxt  = ONE_SLOT;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        cap = 1'b1;
        if (sync_d && (slot != '0)) begin
          // Realign: this word starts a new frame. The partial frame can never
          // reach the last slot, so it produces no frame_valid.
          err      = 1'b1;
          cap_ch   = '0;
          slot_nxt = ONE_SLOT;
        end else begin
          // A sync on slot 0 agrees with the free-running count.
          slot_nxt = (slot == LAST_SLOT) ? '0 : slot + ONE_SLOT;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
    if (cap) dv_nxt[cap_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      slot        <= '0;
      sync_sr     <= '0;
      dout_valid  <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) chan[k] <= '0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      sync_sr[0]  <= sync_in;
      for (int i = 1; i < PIPE_DELAY; i++) sync_sr[i] <= sync_sr[i-1];
      dout_valid  <= dv_nxt;
      frame_valid <= cap && (cap_ch == LAST_SLOT);
      sync_err    <= err;
      if (cap) chan[cap_ch] <= din;
    end
  end

endmodule

// File: tb/tb_rr_tdm_demux.sv
module tb_rr_tdm_demux;

  localparam int W = 16;
  localparam int N = 2;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sync_in = 1'b0;
  logic [W-1:0]   din = '0;
  logic [N*W-1:0] dout;
  logic [N-1:0]   dout_valid;
  logic           frame_valid, locked, sync_err;

  int errors = 0;
  int checks = 0;

  rr_tdm_demux #(.DATA_WIDTH(W), .NUM_CHANNELS(N), .PIPE_DELAY(P)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .din(din),
    .dout(dout), .dout_valid(dout_valid), .frame_valid(frame_valid),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slot of a capture = (cycles since last alignment) mod N. A sync issued in
  // cycle c is seen PIPE_DELAY cycles later unless a reset cycle intervened.
  int           cyc = 0;
  int           last_rst = -1000;
  bit           hist [0:4095];
  int           align = 0;
  bit           m_locked = 0;
  logic [W-1:0] m_ch [N];
  logic [N*W-1:0] exp_dout = '0;
  logic [N-1:0] exp_dv = '0;
  bit           exp_fv = 0, exp_err = 0, exp_locked = 0;
  bit           started = 0;
  int           m_c;
  bit           m_sd, m_cap;

  always @(posedge clk) begin
    exp_dv  = '0;
    exp_fv  = 0;
    exp_err = 0;
    if (rst) begin
      m_locked = 0;
      last_rst = cyc;
      for (int k = 0; k < N; k++) m_ch[k] = '0;
    end else begin
      m_sd  = (cyc - P >= 0) && (cyc - P > last_rst) && hist[cyc-P];
      m_cap = 0;
      m_c   = 0;
      if (m_sd) begin
        exp_err  = m_locked && (((cyc - align) % N) != 0);
        align    = cyc;
        m_locked = 1;
        m_cap    = 1;
        m_c      = 0;
      end else if (m_locked) begin
        m_cap = 1;
        m_c   = (cyc - align) % N;
      end
      if (m_cap) begin
        m_ch[m_c]    = din;
        exp_dv[m_c]  = 1'b1;
        exp_fv       = (m_c == N - 1);
      end
    end
    for (int k = 0; k < N; k++) exp_dout[k*W +: W] = m_ch[k];
    exp_locked = m_locked;
    hist[cyc]  = sync_in;
    cyc++;
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("dout",        64'(dout),        64'(exp_dout));
      chk("dout_valid",  64'(dout_valid),  64'(exp_dv));
      chk("frame_valid", 64'(frame_valid), 64'(exp_fv));
      chk("sync_err",    64'(sync_err),    64'(exp_err));
      chk("locked",      64'(locked),      64'(exp_locked));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic r, input logic s, input logic [W-1:0] d);
    rst = r; sync_in = s; din = d;
    @(posedge clk);
    #1;
  endtask

  int fv_cnt;

  initial begin
    // Reset with random data; a sync during reset must not be stored.
    tick(1'b1, 1'b0, W'($urandom));
    tick(1'b1, 1'b0, W'($urandom));
    tick(1'b1, 1'b1, W'($urandom));
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_dv", 64'(dout_valid), 64'd0);

    // Pre-lock data is ignored.
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, W'(16'h5A5A + i));
      chk("prelock_dout", 64'(dout), 64'd0);
      chk("prelock_vld", 64'({dout_valid, frame_valid, locked}), 64'd0);
    end

    // Acquisition: sync at cycle 0, words at cycles 2 and 3.
    tick(1'b0, 1'b1, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0011);
    chk("acq_ch0", 64'(dout[15:0]), 64'h0011);
    chk("acq_dv0", 64'(dout_valid), 64'b01);
    chk("acq_locked", 64'(locked), 64'd1);
    chk("acq_fv0", 64'(frame_valid), 64'd0);
    tick(1'b0, 1'b0, 16'h0022);
    chk("acq_ch1", 64'(dout[31:16]), 64'h0022);
    chk("acq_dv1", 64'(dout_valid), 64'b10);
    chk("acq_fv1", 64'(frame_valid), 64'd1);

    // Free-run for 20 frames without further sync.
    fv_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick(1'b0, 1'b0, W'(16'hA000 + n));
      fv_cnt += int'(frame_valid);
    end
    chk("freerun_fv_count", 64'(fv_cnt), 64'd20);
    chk("freerun_last", 64'(dout), 64'hA027_A026);

    // Misalignment: sync issued on a slot-1 cycle lands on slot 1.
    tick(1'b0, 1'b0, 16'hB000);
    tick(1'b0, 1'b1, 16'hB001);
    tick(1'b0, 1'b0, 16'hB002);
    tick(1'b0, 1'b0, 16'hB003);
    chk("mis_err", 64'(sync_err), 64'd1);
    chk("mis_ch0", 64'(dout[15:0]), 64'hB003);
    chk("mis_dv", 64'(dout_valid), 64'b01);
    chk("mis_fv", 64'(frame_valid), 64'd0);
    tick(1'b0, 1'b0, 16'hB004);
    chk("mis_next_fv", 64'(frame_valid), 64'd1);
    chk("mis_next_ch1", 64'(dout[31:16]), 64'hB004);
    chk("mis_next_err", 64'(sync_err), 64'd0);

    // Reset mid-frame with a sync pending in the delay line.
    tick(1'b0, 1'b1, 16'hC000);
    chk("mid_dv0", 64'(dout_valid), 64'b01);
    tick(1'b1, 1'b0, 16'hC001);
    chk("mid_rst_dv", 64'(dout_valid), 64'd0);
    chk("mid_rst_locked", 64'(locked), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, W'(16'hC002 + i));
      chk("mid_stay_unlocked", 64'({locked, dout_valid}), 64'd0);
    end
    tick(1'b0, 1'b1, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'hD000);
    chk("relock", 64'(locked), 64'd1);
    chk("relock_ch0", 64'(dout[15:0]), 64'hD000);

    // Back-to-back syncs: the second lands on slot 1.
    tick(1'b0, 1'b1, 16'hE000);
    tick(1'b0, 1'b1, 16'hE001);
    tick(1'b0, 1'b0, 16'hE002);
    tick(1'b0, 1'b0, 16'hE003);
    chk("b2b_err", 64'(sync_err), 64'd1);
    chk("b2b_ch0", 64'(dout[15:0]), 64'hE003);

    // Random traffic, checked against the model only.
    for (int i = 0; i < 300; i++)
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), W'($urandom));
    tick(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_tdm_demux.md
# rr_tdm_demux

Receive-side counterpart to the round-robin TDM mux/multiplier datapath: it takes the single time-multiplexed product stream and de-interleaves it back into one registered output per channel. A frame-sync strobe, issued on the mux side when channel 0 is selected, is delayed internally to match the datapath latency. The block uses it to align a slot counter, detect misalignment and flag complete frames.

## Interface
Parameters:
- DATA_WIDTH, 16, width of the TDM data word (product width).
- NUM_CHANNELS, 2, number of TDM slots per frame; must be ≥2.
- PIPE_DELAY, 2, cycles from sync_in (mux select of channel 0) to the channel-0 word appearing on din; must be ≥1.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- sync_in  in  1  one-cycle pulse, high in the cycle the upstream mux selects channel 0.
- din  in  DATA_WIDTH  TDM data stream, one word per cycle.
- dout  out  NUM_CHANNELS*DATA_WIDTH  channel k held at bits [k*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  out  NUM_CHANNELS  bit k pulses for one cycle when dout channel k updates.
- frame_valid  out  1  one-cycle pulse when all channels of a full frame have updated.
- locked  out  1  high while the slot counter is aligned.
- sync_err  out  1  one-cycle pulse when a sync arrives at the wrong slot.

## Operation
- The sync delay line is a PIPE_DELAY-deep shift register. sync_d is sync_in delayed PIPE_DELAY cycles.
- State machine UNLOCKED / LOCKED, with a slot counter running 0..NUM_CHANNELS-1.
- In UNLOCKED:
  - din is ignored and no outputs update.
  - On sync_d=1, din in that cycle is treated as slot 0: capture it, set the counter to 1, and go to LOCKED.
- In LOCKED:
  - Each cycle, din is captured into channel [slot].
  - The counter increments and wraps from NUM_CHANNELS-1 to 0.
  - The counter free-runs, so sync_in need not repeat every frame.
- A sync_d=1 in LOCKED while slot≠0:
  - pulses sync_err;
  - treats din as slot 0 (capture to channel 0, counter set to 1);
  - discards the partial frame, so no frame_valid is issued for it.
- A sync_d=1 in LOCKED while slot=0 is normal and is not an error.
- frame_valid is issued only when slots 0..NUM_CHANNELS-1 were captured consecutively since the last alignment point, ending with a capture into channel NUM_CHANNELS-1.
- No arithmetic is performed on the data. Words pass through bit-exact; the counter width is clog2(NUM_CHANNELS).

## Timing
- Reset:
  - dout=0, dout_valid=0, frame_valid=0, sync_err=0, locked=0.
  - State UNLOCKED, slot=0, sync delay line cleared.
- Capture latency: din sampled at edge t appears on dout at t+1, with dout_valid[k] high during cycle t+1 only.
- End-to-end latency: sync_in to dout_valid[0] is PIPE_DELAY+1 cycles.
- frame_valid is high in the same cycle as dout_valid[NUM_CHANNELS-1].
- sync_err is high in the same cycle as the realigned dout_valid[0].
- locked rises in the cycle after the first sync_d and stays high until reset.
- dout channels hold their value until the next capture into that channel.
- Reset mid-frame takes effect at the next edge. Any pending syncs in the delay line are lost, and the block must re-acquire from a new sync_in.
- sync_in during reset is ignored; it is not stored in the delay line.
- Back-to-back sync_in pulses each act independently after the delay.

## Test plan
With defaults (DATA_WIDTH=16, NUM_CHANNELS=2, PIPE_DELAY=2):
- Reset: hold rst for 3 cycles with random din -> all outputs 0 and locked=0 during and after reset, until the first sync.
- Acquisition: sync_in at cycle 0, din=0x0011 at cycle 2, din=0x0022 at cycle 3 -> dout[0]=0x0011 with dout_valid=01 at cycle 3; dout[1]=0x0022 with dout_valid=10 and frame_valid=1 at cycle 4; locked=1 from cycle 3.
- Free-run: after lock with no further sync, din alternates 0xA000+n -> channels alternate correctly for 20 frames, with 20 frame_valid pulses.
- Misalignment: while locked, inject sync_in so sync_d lands at slot 1 -> sync_err pulse; that word goes to dout[0]; no frame_valid for the broken frame; the next frame completes normally.
- Reset mid-frame: assert rst after the slot-0 capture -> no dout_valid[1], locked=0; the block re-locks only on a new sync_in.
- Pre-lock data: nonzero din with no sync for 10 cycles -> dout stays 0 and no valid pulses.
